pipe_execute_unit: RTL and testbench
====================================

Name: pipe_execute_unit

Overview:
- Parametrised successor of the pipelined Y86-64 execute stage: ALU, condition-code (CC) register, cmov/jXX condition evaluation, and the E->M pipeline register.
- Adds width generalisation, explicit M-register stall/bubble, and CC-update suppression on downstream exceptions.
- Adds an optional iterative multiplier (OPq ifun=4, mulq) that holds E through a busy/stall request.
- Sits between the decode stage's E register outputs and the memory stage; e_* signals feed decode forwarding and the hazard unit.

Parameters:
- W, 64, datapath width in bits; must be a multiple of 8 and at least 16.
- MUL_EN, 1, 1 = mulq supported; 0 = ifun 4 under OPq is treated as INS.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- E_stat  in  2  stage status (0 AOK, 1 HLT, 2 ADR, 3 INS)
- E_icode  in  4  instruction code
- E_ifun  in  4  function code
- E_valC  in  W  immediate
- E_valA  in  W  operand A
- E_valB  in  W  operand B
- E_dstE  in  4  ALU destination register
- E_dstM  in  4  memory destination register
- m_stat  in  2  memory-stage status, for CC suppression
- W_stat  in  2  writeback-stage status, for CC suppression
- M_stall  in  1  hold M register
- M_bubble  in  1  load NOP into M register
- e_valE  out  W  ALU result, combinational
- e_dstE  out  4  effective dstE, combinational
- e_cnd  out  1  condition result, combinational
- e_busy  out  1  multiplier in progress; hazard unit stalls F/D/E
- cc  out  3  {ZF,SF,OF}
- M_stat  out  2  M register status
- M_icode  out  4  M register instruction code
- M_cnd  out  1  M register condition result
- M_valE  out  W  M register ALU result
- M_valA  out  W  M register operand A
- M_dstE  out  4  M register ALU destination
- M_dstM  out  4  M register memory destination

Behaviour:
- Reset (async, rst_n=0):
  - cc = 3'b100.
  - M register holds a bubble: M_icode=1 (NOP), M_stat=AOK, M_cnd=0, M_valE=M_valA=0, M_dstE=M_dstM=RNONE.
  - Multiplier state = IDLE, e_busy = 0.
- aluA selection:
  - valA for cmov(2) and OPq(6).
  - valC for irmovq(3), rmmovq(4), mrmovq(5).
  - -(W/8) for call(8) and pushq(A).
  - +(W/8) for ret(9) and popq(B).
  - 0 otherwise.
- aluB selection: valB for 4, 5, 6, 8, 9, A, B; 0 otherwise.
- alufun: E_ifun when icode=6, otherwise add.
- ALU ops: add, sub (B-A), and, xor. All arithmetic is modulo 2^W.
- Flags from the W-bit result: ZF = result==0; SF = MSB; OF = signed overflow for add/sub, 0 for logic ops and mul.
- CC write: set_cc = (icode==6) && no non-AOK status on m_stat or W_stat && E_stat==AOK.
  - CC updates at the clock edge when set_cc is high.
  - For mulq, CC updates only in the DONE cycle.
- e_cnd evaluates E_ifun against the registered cc:
  - 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g.
  - ifun >= 7 gives 0.
  - Applies to icodes 2 and 7; other icodes give 0.
- e_dstE = RNONE when icode=2 and e_cnd=0; otherwise E_dstE.
- Multiplier FSM (MUL_EN=1), states IDLE -> MUL -> DONE -> IDLE:
  - IDLE->MUL when icode=6, ifun=4, E_stat=AOK. This happens in the first cycle; e_busy=1 combinationally in that cycle.
  - MUL: shift-add, one multiplier bit per cycle, W cycles. Counter runs W-1..0. e_busy=1.
  - DONE: one cycle, e_busy=0, e_valE = low W bits of valA*valB. The M register captures it normally.
  - Total occupancy is W+1 cycles.
  - If m_stat or W_stat goes non-AOK during MUL: abort to IDLE, e_busy=0, no CC write.
  - Reset mid-operation: IDLE immediately.
- M register update each rising edge, in priority order:
  1. M_stall: hold.
  2. M_bubble, or e_busy=1: load the bubble values.
  3. Otherwise load {E_stat, E_icode, e_cnd, e_valE, E_valA, e_dstE, E_dstM}.
- MUL_EN=0, or ifun > 4 under OPq: M_stat=INS, no CC write, e_busy stays 0.
- E_stat non-AOK: the stage passes it through, suppresses CC write, and never starts a multiply.

Decomposition:
- Shared package y86_pkg:
  - icode constants (HALT..POPQ).
  - ALU function codes, condition codes.
  - stat encodings (AOK/HLT/ADR/INS), RNONE.
- One sub-module: pipe_iter_mul (W-parameterised shift-add multiplier with start/abort/done).
- ALU, condition logic, CC register and M register stay in pipe_execute_unit.

Test Plan:
- Reset then release, with no E activity: cc=100, M_icode=1, M_dstE=F, e_busy=0.
- OPq sub, valA=5, valB=5: e_valE=0, cc=100 after the edge. Then add, valA=1, valB=7FFF_FFFF_FFFF_FFFF: e_valE=8000_0000_0000_0000, cc=011.
- cmovl with cc=010: e_cnd=1, e_dstE=E_dstE. With cc=000: e_cnd=0, e_dstE=F, M_dstE=F next cycle.
- pushq, valB=0x100: e_valE=0xF8, cc unchanged. popq: e_valE=0x108. Repeat with W=32: pushq gives 0xFC.
- mulq, valA=3, valB=-2: e_busy high for 64 cycles and M gets bubbles meanwhile. In the DONE cycle e_valE=FFFF_FFFF_FFFF_FFFA; M_valE holds it next cycle; cc=010.
- OPq add with m_stat=ADR: cc unchanged. mulq with W_stat going to HLT mid-MUL: e_busy drops next cycle, no CC write. M_stall and M_bubble together: M holds.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction and function
// codes, condition codes, stage status values and the multiplier FSM states.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // rrmovq / cmovXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU function codes (ifun under OPq)
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_MUL = 4'h4;

  // Condition codes (ifun under cmovXX / jXX)
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Stage status
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Register ID meaning "no destination"
  localparam logic [3:0] REG_NONE = 4'hF;

  // Condition-code register, packed so that it reads as {ZF,SF,OF}
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  // Iterative multiplier states
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Evaluate a cmov/jXX condition against the current flags.
  function automatic logic cond_eval(input logic [3:0] ifun, input cc_t flags);
    logic lt;
    lt = flags.sf ^ flags.of;
    case (ifun)
      C_YES:   return 1'b1;
      C_LE:    return lt | flags.zf;
      C_L:     return lt;
      C_E:     return flags.zf;
      C_NE:    return ~flags.zf;
      C_GE:    return ~lt;
      C_G:     return ~lt & ~flags.zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_iter_mul.sv
// Shift-add multiplier, one multiplier bit per cycle. Bit 0 is consumed on the
// start edge, bits 1..W-1 in the RUN state, then a single DONE cycle presents
// the low W bits of the product. Busy covers W cycles, occupancy is W+1.
module pipe_iter_mul
  import y86_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_result
);

  localparam int unsigned   CW       = $clog2(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  mul_state_e    r_state;
  mul_state_e    w_next;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_mcand;
  logic [W-1:0]  r_mplier;
  logic [CW-1:0] r_cnt;

  // State register; reset returns to IDLE immediately, abandoning any operation.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MUL_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and status outputs; busy is raised combinationally on start.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      MUL_IDLE: begin
        if (i_start) begin
          o_busy = 1'b1;
          w_next = MUL_RUN;
        end
      end
      MUL_RUN: begin
        o_busy = 1'b1;
        if (i_abort)              w_next = MUL_IDLE;
        else if (r_cnt == ONE_CNT) w_next = MUL_DONE;
      end
      MUL_DONE: begin
        o_done = 1'b1;
        w_next = MUL_IDLE;
      end
      default: w_next = MUL_IDLE;
    endcase
  end

  // Datapath: load operands and bit 0 on start, then accumulate one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (r_state == MUL_IDLE && i_start) begin
      r_acc    <= i_b[0] ? i_a : '0;
      r_mcand  <= i_a << 1;
      r_mplier <= i_b >> 1;
      r_cnt    <= LAST_CNT;
    end else if (r_state == MUL_RUN) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - ONE_CNT;
    end
  end

  assign o_result = r_acc;

endmodule

// File: rtl/pipe_execute_unit.sv
// Y86 execute stage: operand selection, ALU, CC register, cmov/jXX condition,
// optional iterative mulq, and the E->M pipeline register with stall/bubble.
module pipe_execute_unit
  import y86_pkg::*;
#(
  parameter int unsigned W      = 64,
  parameter bit          MUL_EN = 1'b1,
  parameter logic [3:0]  RNONE  = REG_NONE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valC,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [1:0]   m_stat,
  input  logic [1:0]   W_stat,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_cnd,
  output logic         e_busy,
  output logic [2:0]   cc,
  output logic [1:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM
);

  // Stack pointer step: one machine word in bytes.
  localparam logic [W-1:0] WORD_BYTES = W'(W / 8);

  logic [W-1:0] w_alu_a;
  logic [W-1:0] w_alu_b;
  logic [W-1:0] w_alu_res;
  logic [W-1:0] w_mul_res;
  logic [3:0]   w_alufun;
  logic         w_of;
  logic         w_is_opq;
  logic         w_is_mul;
  logic         w_op_valid;
  logic         w_down_ok;
  logic         w_mul_start;
  logic         w_mul_busy;
  logic         w_mul_done;
  logic         w_set_cc;
  logic [1:0]   w_e_stat;
  cc_t          w_flags;
  cc_t          r_cc;

  // Instruction classification and exception gating.
  assign w_is_opq   = (E_icode == I_OPQ);
  assign w_is_mul   = w_is_opq && (E_ifun == ALU_MUL) && MUL_EN;
  assign w_op_valid = !w_is_opq || (E_ifun <= ALU_XOR) || w_is_mul;
  assign w_down_ok  = (m_stat == STAT_AOK) && (W_stat == STAT_AOK);
  assign w_e_stat   = (E_stat == STAT_AOK && !w_op_valid) ? STAT_INS : E_stat;

  // A multiply behind a downstream exception would be flushed anyway, so it
  // is not started; one already running is aborted by the same condition.
  assign w_mul_start = w_is_mul && (E_stat == STAT_AOK) && w_down_ok;

  pipe_iter_mul #(
    .W (W)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_mul_start),
    .i_abort  (!w_down_ok),
    .i_a      (E_valA),
    .i_b      (E_valB),
    .o_busy   (w_mul_busy),
    .o_done   (w_mul_done),
    .o_result (w_mul_res)
  );

  assign e_busy = w_mul_busy;

  // ALU operand A selection by instruction class.
  always_comb begin
    w_alu_a = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:            w_alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alu_a = E_valC;
      I_CALL, I_PUSHQ:            w_alu_a = -WORD_BYTES;
      I_RET, I_POPQ:              w_alu_a = WORD_BYTES;
      default:                    w_alu_a = '0;
    endcase
  end

  // ALU operand B selection by instruction class.
  always_comb begin
    w_alu_b = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
      I_RET, I_PUSHQ, I_POPQ: w_alu_b = E_valB;
      default:                w_alu_b = '0;
    endcase
  end

  assign w_alufun = w_is_opq ? E_ifun : ALU_ADD;

  // ALU result and signed-overflow detection (overflow only for add/sub).
  always_comb begin
    w_alu_res = '0;
    w_of      = 1'b0;
    case (w_alufun)
      ALU_ADD: begin
        w_alu_res = w_alu_b + w_alu_a;
        w_of      = (w_alu_a[W-1] == w_alu_b[W-1]) && (w_alu_res[W-1] != w_alu_a[W-1]);
      end
      ALU_SUB: begin
        w_alu_res = w_alu_b - w_alu_a;
        w_of      = (w_alu_a[W-1] != w_alu_b[W-1]) && (w_alu_res[W-1] != w_alu_b[W-1]);
      end
      ALU_AND: w_alu_res = w_alu_b & w_alu_a;
      ALU_XOR: w_alu_res = w_alu_b ^ w_alu_a;
      ALU_MUL: w_alu_res = MUL_EN ? w_mul_res : '0;
      default: w_alu_res = '0;
    endcase
  end

  assign e_valE     = w_alu_res;
  assign w_flags.zf = (w_alu_res == '0);
  assign w_flags.sf = w_alu_res[W-1];
  assign w_flags.of = w_of;

  // Flags are written only by a valid OPq with a clean pipeline; mulq only
  // writes once its product is presented in the DONE cycle.
  assign w_set_cc = w_is_opq && w_op_valid && (E_stat == STAT_AOK) && w_down_ok &&
                    (!w_is_mul || w_mul_done);

  // Condition-code register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cc <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
    else if (w_set_cc) r_cc <= w_flags;
  end

  assign cc = r_cc;

  // Condition evaluation for cmovXX and jXX against the registered flags.
  always_comb begin
    e_cnd = 1'b0;
    if (E_icode == I_RRMOVQ || E_icode == I_JXX) e_cnd = cond_eval(E_ifun, r_cc);
  end

  // A cmov whose condition fails writes no register.
  assign e_dstE = (E_icode == I_RRMOVQ && !e_cnd) ? RNONE : E_dstE;

  // E->M pipeline register: stall holds, bubble or multiplier busy inserts a NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (M_stall) begin
      M_stat  <= M_stat;
    end else if (M_bubble || w_mul_busy) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_stat  <= w_e_stat;
      M_icode <= E_icode;
      M_cnd   <= e_cnd;
      M_valE  <= w_alu_res;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_pipe_execute_unit.sv
// Self-checking bench for pipe_execute_unit: directed scenarios plus random
// instruction streams compared against an arithmetic reference model.
module tb_pipe_execute_unit;
  import y86_pkg::*;

  localparam int unsigned W  = 64;
  localparam int unsigned W2 = 32;
  localparam logic [W-1:0] BYTES = 64'd8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]   E_stat, m_stat, W_stat;
  logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM;
  logic [W-1:0] E_valC, E_valA, E_valB;
  logic         M_stall, M_bubble;

  logic [W-1:0] e_valE, M_valE, M_valA;
  logic [3:0]   e_dstE, M_icode, M_dstE, M_dstM;
  logic         e_cnd, e_busy, M_cnd;
  logic [2:0]   cc;
  logic [1:0]   M_stat;

  logic [W2-1:0] s_valE, s_M_valE, s_M_valA;
  logic [3:0]    s_dstE, s_M_icode, s_M_dstE, s_M_dstM;
  logic          s_cnd, s_busy, s_M_cnd;
  logic [2:0]    s_cc;
  logic [1:0]    s_M_stat;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_cc;

  pipe_execute_unit #(.W(W), .MUL_EN(1'b1), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .e_busy(e_busy), .cc(cc),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  pipe_execute_unit #(.W(W2), .MUL_EN(1'b0), .RNONE(4'hF)) dut32 (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC[W2-1:0]), .E_valA(E_valA[W2-1:0]), .E_valB(E_valB[W2-1:0]),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(s_valE), .e_dstE(s_dstE), .e_cnd(s_cnd), .e_busy(s_busy), .cc(s_cc),
    .M_stat(s_M_stat), .M_icode(s_M_icode), .M_cnd(s_M_cnd), .M_valE(s_M_valE),
    .M_valA(s_M_valA), .M_dstE(s_M_dstE), .M_dstM(s_M_dstM)
  );

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_valE(input logic [3:0] ic, input logic [3:0] fn,
                                              input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c);
    case (ic)
      I_RRMOVQ:           return a;
      I_IRMOVQ:           return c;
      I_RMMOVQ, I_MRMOVQ: return b + c;
      I_OPQ: begin
        case (fn)
          4'd0:    return b + a;
          4'd1:    return b - a;
          4'd2:    return b & a;
          4'd3:    return b ^ a;
          4'd4:    return b * a;
          default: return '0;
        endcase
      end
      I_CALL, I_PUSHQ:    return b - BYTES;
      I_RET, I_POPQ:      return b + BYTES;
      default:            return '0;
    endcase
  endfunction

  // Flags {ZF,SF,OF}: overflow is "true signed result not representable in W bits".
  function automatic logic [2:0] model_flags(input logic [3:0] fn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0]   r;
    logic signed [W:0] full;
    logic ovf;
    r   = model_valE(I_OPQ, fn, a, b, '0);
    ovf = 1'b0;
    if (fn == 4'd0) begin
      full = $signed({a[W-1], a}) + $signed({b[W-1], b});
      ovf  = (full != $signed({r[W-1], r}));
    end else if (fn == 4'd1) begin
      full = $signed({b[W-1], b}) - $signed({a[W-1], a});
      ovf  = (full != $signed({r[W-1], r}));
    end
    return {(r == '0), r[W-1], ovf};
  endfunction

  function automatic logic model_cond(input logic [3:0] fn, input logic [2:0] f);
    logic zf, sf, of;
    {zf, sf, of} = f;
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (sf != of) || zf;
      4'd2:    return sf != of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return sf == of;
      4'd6:    return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [3:0] de, input logic [3:0] dm);
    E_stat = st; E_icode = ic; E_ifun = fn; E_valA = a; E_valB = b; E_valC = c;
    E_dstE = de; E_dstM = dm;
    #1;
  endtask

  task automatic drive_nop();
    drive(STAT_AOK, I_NOP, 4'h0, '0, '0, '0, 4'hF, 4'hF);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; m_stat = STAT_AOK; W_stat = STAT_AOK; M_stall = 1'b0; M_bubble = 1'b0;
    drive_nop();
    #10;
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL reset_cc: got %b exp 100", cc); end
    checks++; if (M_icode !== I_NOP) begin errors++; $display("FAIL reset_M_icode: got %h exp 1", M_icode); end
    checks++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin errors++; $display("FAIL reset_M_dst: got %h/%h exp F/F", M_dstE, M_dstM); end
    checks++; if (M_valE !== '0 || M_stat !== STAT_AOK || M_cnd !== 1'b0) begin errors++; $display("FAIL reset_M_fields: valE %h stat %0d cnd %b exp 0/0/0", M_valE, M_stat, M_cnd); end
    checks++; if (e_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", e_busy); end
    rst_n = 1'b1;
    tick();
    checks++; if (cc !== 3'b100 || M_icode !== I_NOP || M_dstE !== 4'hF || e_busy !== 1'b0) begin errors++; $display("FAIL post_reset: cc %b icode %h dstE %h busy %b exp 100/1/F/0", cc, M_icode, M_dstE, e_busy); end
    exp_cc = 3'b100;
  endtask

  task automatic test_opq_directed();
    drive(STAT_AOK, I_OPQ, ALU_SUB, 64'd5, 64'd5, '0, 4'h3, 4'hF);
    checks++; if (e_valE !== 64'd0) begin errors++; $display("FAIL sub_valE: got %h exp 0", e_valE); end
    tick();
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL sub_cc: got %b exp 100", cc); end
    drive(STAT_AOK, I_OPQ, ALU_ADD, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, '0, 4'h3, 4'hF);
    checks++; if (e_valE !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_ovf_valE: got %h exp 8000000000000000", e_valE); end
    tick();
    checks++; if (cc !== 3'b011) begin errors++; $display("FAIL add_ovf_cc: got %b exp 011", cc); end
    checks++; if (M_valE !== 64'h8000_0000_0000_0000 || M_icode !== I_OPQ) begin errors++; $display("FAIL add_ovf_M: valE %h icode %h", M_valE, M_icode); end
    exp_cc = 3'b011;
  endtask

  task automatic test_cmov();
    drive(STAT_AOK, I_OPQ, ALU_SUB, 64'd1, 64'd0, '0, 4'h3, 4'hF);  // 0-1 -> cc 010
    tick();
    checks++; if (cc !== 3'b010) begin errors++; $display("FAIL cmov_setup_cc: got %b exp 010", cc); end
    drive(STAT_AOK, I_RRMOVQ, C_L, 64'hABCD, '0, '0, 4'h7, 4'hF);
    checks++; if (e_cnd !== 1'b1 || e_dstE !== 4'h7) begin errors++; $display("FAIL cmovl_taken: cnd %b dstE %h exp 1/7", e_cnd, e_dstE); end
    drive(STAT_AOK, I_OPQ, ALU_ADD, 64'd1, 64'd1, '0, 4'h3, 4'hF);  // 1+1 -> cc 000
    tick();
    drive(STAT_AOK, I_RRMOVQ, C_L, 64'hABCD, '0, '0, 4'h7, 4'hF);
    checks++; if (e_cnd !== 1'b0 || e_dstE !== 4'hF) begin errors++; $display("FAIL cmovl_not_taken: cnd %b dstE %h exp 0/F", e_cnd, e_dstE); end
    tick();
    checks++; if (M_dstE !== 4'hF || M_cnd !== 1'b0) begin errors++; $display("FAIL cmovl_M: dstE %h cnd %b exp F/0", M_dstE, M_cnd); end
    exp_cc = 3'b000;
  endtask

  task automatic test_push_pop();
    drive(STAT_AOK, I_PUSHQ, 4'h0, 64'h55, 64'h100, '0, 4'h4, 4'hF);
    checks++; if (e_valE !== 64'hF8) begin errors++; $display("FAIL push64: got %h exp F8", e_valE); end
    checks++; if (s_valE !== 32'hFC) begin errors++; $display("FAIL push32: got %h exp FC", s_valE); end
    tick();
    checks++; if (cc !== exp_cc) begin errors++; $display("FAIL push_cc: got %b exp %b", cc, exp_cc); end
    drive(STAT_AOK, I_POPQ, 4'h0, 64'h100, 64'h100, '0, 4'h4, 4'h2);
    checks++; if (e_valE !== 64'h108) begin errors++; $display("FAIL pop64: got %h exp 108", e_valE); end
    checks++; if (s_valE !== 32'h104) begin errors++; $display("FAIL pop32: got %h exp 104", s_valE); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] ic, fn, de, dm;
    logic [W-1:0] a, b, c, xv;
    logic xc;
    logic [3:0] xd;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: ic = I_RRMOVQ; 1: ic = I_IRMOVQ; 2: ic = I_RMMOVQ; 3: ic = I_MRMOVQ;
        4, 5: ic = I_OPQ; 6: ic = I_JXX; 7: ic = I_CALL; 8: ic = I_RET;
        default: ic = ($urandom_range(0, 1) == 0) ? I_PUSHQ : I_POPQ;
      endcase
      fn = (ic == I_OPQ) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 8));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      c  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = a;  // exercise ZF
      de = 4'($urandom_range(0, 14));
      dm = 4'($urandom_range(0, 15));
      drive(STAT_AOK, ic, fn, a, b, c, de, dm);
      xv = model_valE(ic, fn, a, b, c);
      xc = (ic == I_RRMOVQ || ic == I_JXX) ? model_cond(fn, exp_cc) : 1'b0;
      xd = (ic == I_RRMOVQ && !xc) ? 4'hF : de;
      checks++; if (e_valE !== xv) begin errors++; $display("FAIL rand_valE[%0d] ic %h fn %h: got %h exp %h", i, ic, fn, e_valE, xv); end
      checks++; if (e_cnd !== xc || e_dstE !== xd) begin errors++; $display("FAIL rand_cnd[%0d] ic %h fn %h cc %b: got %b/%h exp %b/%h", i, ic, fn, exp_cc, e_cnd, e_dstE, xc, xd); end
      if (ic == I_OPQ) exp_cc = model_flags(fn, a, b);
      tick();
      checks++; if (cc !== exp_cc) begin errors++; $display("FAIL rand_cc[%0d] ic %h fn %h: got %b exp %b", i, ic, fn, cc, exp_cc); end
      checks++; if (M_valE !== xv || M_icode !== ic || M_dstE !== xd || M_cnd !== xc || M_valA !== a || M_dstM !== dm || M_stat !== STAT_AOK) begin
        errors++; $display("FAIL rand_M[%0d]: valE %h icode %h dstE %h cnd %b exp %h/%h/%h/%b", i, M_valE, M_icode, M_dstE, M_cnd, xv, ic, xd, xc);
      end
    end
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    int bub_bad;
    logic [W-1:0] prod;
    logic [2:0] cc_before;
    prod = a * b;
    cc_before = exp_cc;
    drive(STAT_AOK, I_OPQ, ALU_MUL, a, b, '0, 4'h5, 4'hF);
    n = 0;
    bub_bad = 0;
    while (e_busy === 1'b1 && n < W + 8) begin
      n++;
      tick();
      if (M_icode !== I_NOP || M_dstE !== 4'hF) bub_bad++;
    end
    checks++; if (n != W) begin errors++; $display("FAIL mul_busy_cycles: got %0d exp %0d", n, W); end
    checks++; if (bub_bad != 0) begin errors++; $display("FAIL mul_bubbles: %0d non-bubble M cycles exp 0", bub_bad); end
    checks++; if (e_valE !== prod || e_busy !== 1'b0) begin errors++; $display("FAIL mul_done_valE: got %h busy %b exp %h/0", e_valE, e_busy, prod); end
    checks++; if (cc !== cc_before) begin errors++; $display("FAIL mul_cc_hold: got %b exp %b", cc, cc_before); end
    tick();
    drive_nop();
    exp_cc = {(prod == '0), prod[W-1], 1'b0};
    checks++; if (M_valE !== prod || M_icode !== I_OPQ || M_dstE !== 4'h5) begin errors++; $display("FAIL mul_M: valE %h icode %h dstE %h exp %h/6/5", M_valE, M_icode, M_dstE, prod); end
    checks++; if (cc !== exp_cc) begin errors++; $display("FAIL mul_cc: got %b exp %b", cc, exp_cc); end
    tick();
  endtask

  task automatic test_mulq();
    run_mul(64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
    run_mul({$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic test_exceptions();
    drive(STAT_AOK, I_OPQ, ALU_ADD, 64'd1, 64'd1, '0, 4'h3, 4'hF);
    tick();
    exp_cc = 3'b000;
    m_stat = STAT_ADR;
    drive(STAT_AOK, I_OPQ, ALU_ADD, 64'd0, 64'd0, '0, 4'h3, 4'hF);
    tick();
    checks++; if (cc !== 3'b000) begin errors++; $display("FAIL cc_suppress_m: got %b exp 000", cc); end
    m_stat = STAT_AOK;
    drive(STAT_HLT, I_OPQ, ALU_SUB, 64'd1, 64'd0, '0, 4'h3, 4'hF);
    tick();
    checks++; if (cc !== 3'b000 || M_stat !== STAT_HLT) begin errors++; $display("FAIL e_stat_hlt: cc %b M_stat %0d exp 000/1", cc, M_stat); end
    drive(STAT_AOK, I_OPQ, 4'h5, 64'd0, 64'd0, '0, 4'h3, 4'hF);
    tick();
    checks++; if (cc !== 3'b000 || M_stat !== STAT_INS) begin errors++; $display("FAIL bad_ifun: cc %b M_stat %0d exp 000/3", cc, M_stat); end
    drive(STAT_ADR, I_OPQ, ALU_MUL, 64'd3, 64'd3, '0, 4'h3, 4'hF);
    checks++; if (e_busy !== 1'b0) begin errors++; $display("FAIL mul_bad_stat_busy: got %b exp 0", e_busy); end
    tick();
    // Narrow instance has no multiplier: mulq becomes INS and never busies.
    W_stat = STAT_HLT;
    drive(STAT_AOK, I_OPQ, ALU_MUL, 64'd3, 64'd3, '0, 4'h3, 4'hF);
    checks++; if (s_busy !== 1'b0 || e_busy !== 1'b0) begin errors++; $display("FAIL mul_disabled_busy: got %b/%b exp 0/0", s_busy, e_busy); end
    tick();
    checks++; if (s_M_stat !== STAT_INS) begin errors++; $display("FAIL mul_disabled_stat: got %0d exp 3", s_M_stat); end
    W_stat = STAT_AOK;
    // Abort mid-multiply when writeback raises HLT.
    drive(STAT_AOK, I_OPQ, ALU_MUL, 64'd7, 64'd9, '0, 4'h3, 4'hF);
    for (int i = 0; i < 10; i++) tick();
    W_stat = STAT_HLT;
    #1;
    checks++; if (e_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b exp 1", e_busy); end
    tick();
    checks++; if (e_busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b exp 0", e_busy); end
    checks++; if (cc !== exp_cc) begin errors++; $display("FAIL abort_cc: got %b exp %b", cc, exp_cc); end
    drive_nop();
    W_stat = STAT_AOK;
    tick();
  endtask

  task automatic test_stall_bubble();
    drive(STAT_AOK, I_IRMOVQ, 4'h0, '0, '0, 64'h1234, 4'h5, 4'hF);
    tick();
    checks++; if (M_valE !== 64'h1234 || M_icode !== I_IRMOVQ) begin errors++; $display("FAIL irmov_M: valE %h icode %h exp 1234/3", M_valE, M_icode); end
    M_stall = 1'b1; M_bubble = 1'b1;
    drive(STAT_AOK, I_RRMOVQ, C_YES, 64'h99, '0, '0, 4'h2, 4'hF);
    tick();
    checks++; if (M_valE !== 64'h1234 || M_icode !== I_IRMOVQ || M_dstE !== 4'h5) begin errors++; $display("FAIL stall_hold: valE %h icode %h dstE %h exp 1234/3/5", M_valE, M_icode, M_dstE); end
    M_stall = 1'b0;
    tick();
    checks++; if (M_icode !== I_NOP || M_dstE !== 4'hF || M_valE !== '0) begin errors++; $display("FAIL bubble: icode %h dstE %h valE %h exp 1/F/0", M_icode, M_dstE, M_valE); end
    M_bubble = 1'b0;
    drive_nop();
    tick();
  endtask

  initial begin
    test_reset();
    test_opq_directed();
    test_cmov();
    test_push_pop();
    test_random();
    test_mulq();
    test_exceptions();
    test_stall_bubble();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
